// File: rtl/cam_pkg.sv
// Shared encodings and colour constants for the camera-bus pattern generator.
package cam_pkg;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_SOLID   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_CROSS   = 2'd3
    } pattern_t;

    typedef enum logic {
        FMT_RGB444 = 1'b0,
        FMT_RGB565 = 1'b1
    } fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VS_PRE,
        ST_VS_HIGH,
        ST_VS_POST,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    // Ordered to match the colour-bar sequence so a bar index casts directly.
    typedef enum logic [2:0] {
        C_RED, C_GREEN, C_BLUE, C_YELLOW, C_CYAN, C_MAGENTA, C_WHITE, C_BLACK
    } color_t;

    localparam logic [15:0] RED_444   = 16'h0F00;
    localparam logic [15:0] GREEN_444 = 16'h00F0;
    localparam logic [15:0] BLUE_444  = 16'h000F;
    localparam logic [15:0] RED_565   = 16'hF800;
    localparam logic [15:0] GREEN_565 = 16'h07E0;
    localparam logic [15:0] BLUE_565  = 16'h001F;

    function automatic logic [15:0] color_word(input fmt_t fmt, input color_t c);
        logic [15:0] r, g, b;
        r = (fmt == FMT_RGB565) ? RED_565   : RED_444;
        g = (fmt == FMT_RGB565) ? GREEN_565 : GREEN_444;
        b = (fmt == FMT_RGB565) ? BLUE_565  : BLUE_444;
        case (c)
            C_RED:     return r;
            C_GREEN:   return g;
            C_BLUE:    return b;
            C_YELLOW:  return r | g;
            C_CYAN:    return g | b;
            C_MAGENTA: return r | b;
            C_WHITE:   return r | g | b;
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/cam_pattern_color.sv
// Combinational pixel-word generator: maps (x, y) and the latched pattern setup to a 16-bit word.
module cam_pattern_color
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH    = 176,
    parameter int unsigned HEIGHT   = 144,
    parameter int unsigned CHK_LOG2 = 3,
    parameter int unsigned XW       = $clog2(WIDTH + 1),
    parameter int unsigned YW       = $clog2(HEIGHT + 1)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_t      pattern,
    input  fmt_t          fmt,
    input  logic [15:0]   solid,
    output logic [15:0]   word
);

    localparam int unsigned BAR_W = ((WIDTH >> 3) == 0) ? 1 : (WIDTH >> 3);

    logic [31:0] bar;
    logic [31:0] cx, cy;

    always_comb begin
        word = '0;
        bar  = 32'(x) / BAR_W;
        if (bar > 32'd7)
            bar = 32'd7;
        cx = 32'(x) >> CHK_LOG2;
        cy = 32'(y) >> CHK_LOG2;
        case (pattern)
            PAT_BARS:    word = color_word(fmt, color_t'(bar[2:0]));
            PAT_SOLID:   word = solid;
            PAT_CHECKER: word = (cx[0] ^ cy[0]) ? color_word(fmt, C_BLACK)
                                                : color_word(fmt, C_WHITE);
            default:     word = (32'(x) == 32'(WIDTH / 2) || 32'(y) == 32'(HEIGHT / 2))
                                ? color_word(fmt, C_YELLOW) : color_word(fmt, C_CYAN);
        endcase
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// OV7670-style VSYNC/HREF/DATA frame source with configurable geometry, format and test pattern.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH    = 176,
    parameter int unsigned HEIGHT   = 144,
    parameter int unsigned H_BLANK  = 8,
    parameter int unsigned VS_PRE   = 1,
    parameter int unsigned VS_HIGH  = 2,
    parameter int unsigned VS_POST  = 1,
    parameter int unsigned V_BLANK  = 1000,
    parameter int unsigned CHK_LOG2 = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic        FMT,
    input  logic [1:0]  PATTERN,
    input  logic [15:0] SOLID_COLOR,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  DATA,
    output logic        FRAME_DONE,
    output logic [15:0] FRAME_CNT
);

    localparam int unsigned XW   = $clog2(WIDTH + 1);
    localparam int unsigned YW   = $clog2(HEIGHT + 1);
    localparam int unsigned M1   = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned M2   = (M1 > 2 * WIDTH) ? M1 : 2 * WIDTH;
    localparam int unsigned M3   = (M2 > VS_PRE + VS_HIGH + VS_POST) ? M2 : VS_PRE + VS_HIGH + VS_POST;
    localparam int unsigned CW   = $clog2(M3 + 1);

    localparam logic [CW-1:0] L_PRE  = CW'(VS_PRE - 1);
    localparam logic [CW-1:0] L_HIGH = CW'(VS_HIGH - 1);
    localparam logic [CW-1:0] L_POST = CW'(VS_POST - 1);
    localparam logic [CW-1:0] L_ACT  = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0] L_HB   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] L_VB   = CW'(V_BLANK - 1);

    if (WIDTH == 0 || HEIGHT == 0 || H_BLANK == 0 || VS_PRE == 0 ||
        VS_HIGH == 0 || VS_POST == 0 || V_BLANK == 0) begin : g_bad_param
        $error("cam_pattern_gen: geometry and blanking parameters must be non-zero");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic [XW-1:0] x, x_sel;
    logic [YW-1:0] y;
    pattern_t      cfg_pattern;
    fmt_t          cfg_fmt;
    logic [15:0]   cfg_solid;
    logic [15:0]   word;

    // DATA is registered, so the lookup targets the pixel of the next cycle: after an
    // odd (low) byte the next byte is the high byte of x+1. Byte phase is cnt[0].
    assign x_sel = (state == ST_ACTIVE && cnt[0]) ? x + 1'b1 : x;

    cam_pattern_color #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .CHK_LOG2 (CHK_LOG2),
        .XW       (XW),
        .YW       (YW)
    ) u_color (
        .x       (x_sel),
        .y       (y),
        .pattern (cfg_pattern),
        .fmt     (cfg_fmt),
        .solid   (cfg_solid),
        .word    (word)
    );

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            cfg_pattern <= PAT_BARS;
            cfg_fmt     <= FMT_RGB444;
            cfg_solid   <= '0;
            VSYNC       <= 1'b0;
            HREF        <= 1'b0;
            DATA        <= '0;
            FRAME_DONE  <= 1'b0;
            FRAME_CNT   <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (EN) begin
                        state       <= ST_VS_PRE;
                        cnt         <= '0;
                        cfg_pattern <= pattern_t'(PATTERN);
                        cfg_fmt     <= fmt_t'(FMT);
                        cfg_solid   <= SOLID_COLOR;
                    end
                end
                ST_VS_PRE: begin
                    if (cnt == L_PRE) begin
                        state <= ST_VS_HIGH;
                        cnt   <= '0;
                        VSYNC <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_VS_HIGH: begin
                    if (cnt == L_HIGH) begin
                        state <= ST_VS_POST;
                        cnt   <= '0;
                        VSYNC <= 1'b0;
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_VS_POST: begin
                    if (cnt == L_POST) begin
                        state <= ST_ACTIVE;
                        cnt   <= '0;
                        HREF  <= 1'b1;
                        DATA  <= word[15:8];
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_ACTIVE: begin
                    if (cnt == L_ACT) begin
                        state <= ST_HBLANK;
                        cnt   <= '0;
                        HREF  <= 1'b0;
                        DATA  <= '0;
                        x     <= '0;
                        y     <= y + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt[0]) begin
                            x    <= x + 1'b1;
                            DATA <= word[15:8];
                        end else
                            DATA <= word[7:0];
                    end
                end
                ST_HBLANK: begin
                    if (cnt == L_HB) begin
                        cnt <= '0;
                        if (y == YW'(HEIGHT)) begin
                            state <= ST_VBLANK;
                            if (V_BLANK == 1) begin
                                FRAME_DONE <= 1'b1;
                                FRAME_CNT  <= FRAME_CNT + 1'b1;
                                y          <= '0;
                            end
                        end else begin
                            state <= ST_ACTIVE;
                            HREF  <= 1'b1;
                            DATA  <= word[15:8];
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_VBLANK: begin
                    if (cnt == L_VB) begin
                        cnt <= '0;
                        if (EN) begin
                            state       <= ST_VS_PRE;
                            cfg_pattern <= pattern_t'(PATTERN);
                            cfg_fmt     <= fmt_t'(FMT);
                            cfg_solid   <= SOLID_COLOR;
                        end else
                            state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == L_VB) begin
                            FRAME_DONE <= 1'b1;
                            FRAME_CNT  <= FRAME_CNT + 1'b1;
                            y          <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Scoreboard bench: stimulus queues expected pixel bytes per frame, a monitor checks the camera bus.
module tb_cam_pattern_gen;

    localparam int W   = 24;
    localparam int H   = 6;
    localparam int HB  = 8;
    localparam int VB  = 10;
    localparam int VSP = 1;
    localparam int VSH = 2;
    localparam int VSO = 1;
    localparam int CL  = 1;
    localparam int PERIOD = VSP + VSH + VSO + H * (2 * W + HB) + VB;
    localparam int NFR = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        FMT = 1'b0;
    logic [1:0]  PATTERN = 2'd0;
    logic [15:0] SOLID_COLOR = 16'h0;
    logic        VSYNC, HREF, FRAME_DONE;
    logic [7:0]  DATA;
    logic [15:0] FRAME_CNT;

    cam_pattern_gen #(
        .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .VS_PRE(VSP), .VS_HIGH(VSH),
        .VS_POST(VSO), .V_BLANK(VB), .CHK_LOG2(CL)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .FMT(FMT), .PATTERN(PATTERN),
        .SOLID_COLOR(SOLID_COLOR), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
        .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] byte_q[$];
    bit mon_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] pack(input bit fmt, input bit r, input bit g, input bit b);
        if (fmt) return {r ? 5'h1F : 5'h00, g ? 6'h3F : 6'h00, b ? 5'h1F : 5'h00};
        return {4'h0, r ? 4'hF : 4'h0, g ? 4'hF : 4'h0, b ? 4'hF : 4'h0};
    endfunction

    // Reference pixel from the pattern definitions, expressed as RGB primaries.
    function automatic logic [15:0] ref_pixel(input int x, input int y, input bit fmt,
                                              input int pat, input logic [15:0] solid);
        int bar;
        case (pat)
            0: begin
                bar = x / (W / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: return pack(fmt, 1, 0, 0);
                    1: return pack(fmt, 0, 1, 0);
                    2: return pack(fmt, 0, 0, 1);
                    3: return pack(fmt, 1, 1, 0);
                    4: return pack(fmt, 0, 1, 1);
                    5: return pack(fmt, 1, 0, 1);
                    6: return pack(fmt, 1, 1, 1);
                    default: return pack(fmt, 0, 0, 0);
                endcase
            end
            1: return solid;
            2: return (((x / (2 ** CL)) + (y / (2 ** CL))) % 2 == 1) ? pack(fmt, 0, 0, 0)
                                                                    : pack(fmt, 1, 1, 1);
            default: return (x == W / 2 || y == H / 2) ? pack(fmt, 1, 1, 0) : pack(fmt, 0, 1, 1);
        endcase
    endfunction

    task automatic start_frame(input bit fmt, input int pat, input logic [15:0] solid);
        logic [15:0] w;
        FMT = fmt;
        PATTERN = 2'(pat);
        SOLID_COLOR = solid;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                w = ref_pixel(x, y, fmt, pat, solid);
                byte_q.push_back(w[15:8]);
                byte_q.push_back(w[7:0]);
            end
    endtask

    // Monitor
    bit prev_href = 0, prev_vs = 0, first_done = 1;
    int burst_len = 0, vs_len = 0, rows = 0, frames_seen = 0, vs_pulses = 0;
    int cyc = 0, last_done = 0;
    logic [7:0] exp_b;

    always @(posedge CLK) begin
        cyc++;
        if (mon_on && RST_N) begin
            if (HREF) begin
                if (byte_q.size() == 0) check("unexpected_href", 1, 0);
                else begin
                    exp_b = byte_q.pop_front();
                    check("data", int'(DATA), int'(exp_b));
                end
                burst_len++;
            end else begin
                check("data_idle", int'(DATA), 0);
                if (prev_href) begin
                    check("burst_len", burst_len, 2 * W);
                    burst_len = 0;
                    rows++;
                end
            end
            if (VSYNC) vs_len++;
            else if (prev_vs) begin
                check("vsync_len", vs_len, VSH);
                vs_len = 0;
                vs_pulses++;
            end
            if (FRAME_DONE) begin
                frames_seen++;
                check("frame_cnt", int'(FRAME_CNT), frames_seen);
                check("rows", rows, H);
                rows = 0;
                if (!first_done) check("period", cyc - last_done, PERIOD);
                last_done = cyc;
                first_done = 0;
            end
            prev_href = HREF;
            prev_vs = VSYNC;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, busy;
        repeat (3) @(posedge CLK);
        check("rst_vsync", int'(VSYNC), 0);
        check("rst_href", int'(HREF), 0);
        check("rst_data", int'(DATA), 0);
        check("rst_done", int'(FRAME_DONE), 0);
        check("rst_cnt", int'(FRAME_CNT), 0);
        RST_N = 1'b1;

        // Abort a frame mid-row with an asynchronous reset.
        @(posedge CLK);
        EN = 1'b1;
        repeat (20) @(negedge CLK);
        @(posedge CLK);
        check("pre_reset_href", int'(HREF), 1);
        RST_N = 1'b0;
        #1;
        check("async_href", int'(HREF), 0);
        check("async_data", int'(DATA), 0);
        check("async_vsync", int'(VSYNC), 0);
        EN = 1'b0;
        @(posedge CLK);
        RST_N = 1'b1;
        busy = 0;
        repeat (30) begin
            @(posedge CLK);
            if (HREF || VSYNC || FRAME_DONE) busy++;
        end
        check("idle_after_reset", busy, 0);
        check("cnt_after_reset", int'(FRAME_CNT), 0);

        // Scoreboarded frames: every pattern in both formats, mid-frame config scrambling.
        @(posedge CLK);
        mon_on = 1'b1;
        EN = 1'b1;
        start_frame(1'b0, 0, 16'(($urandom)));
        for (int f = 0; f < NFR; f++) begin
            @(negedge CLK);
            r = (f == NFR - 1) ? (VSP + VSH + VSO + 2 * (2 * W + HB) + 5)
                               : int'($urandom_range(PERIOD - 10, 5));
            repeat (r) @(negedge CLK);
            @(posedge CLK);
            FMT = 1'($urandom);
            PATTERN = 2'($urandom);
            SOLID_COLOR = 16'($urandom);
            if (f == NFR - 1) EN = 1'b0;
            repeat (PERIOD - 1 - r) @(negedge CLK);
            @(posedge CLK);
            if (f < NFR - 1)
                start_frame(1'((f + 1) / 4), (f + 1) % 4,
                            (f + 1 == 1) ? 16'hABCD : 16'($urandom));
        end

        busy = 0;
        repeat (3 * PERIOD) begin
            @(posedge CLK);
            if (HREF || VSYNC) busy++;
        end
        check("idle_after_en_drop", busy, 0);
        check("frames_seen", frames_seen, NFR);
        check("vsync_pulses", vs_pulses, NFR);
        check("final_frame_cnt", int'(FRAME_CNT), NFR);
        check("bytes_left", byte_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
